// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Responder end of the processor's data-memory interface. It is a
//            word-addressed data memory that services one load/store request
//            at a time from the MEM stage. Each access is delayed by a
//            programmable number of wait states, and the response is held
//            until the initiator takes it.
// Ports    :
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  initiator presents a request
//   req_ready  responder can accept a request this cycle (IDLE only)
//   req_write  1 = store, 0 = load
//   req_addr   16-bit word address; bits above ADDR_W must be zero
//   req_wdata  store data
//   rsp_valid  response available, held until rsp_ready
//   rsp_ready  initiator consumes the response
//   rsp_rdata  load data; 0 for stores and for out-of-range loads
//   rsp_err    address out of range
//   busy       transaction in flight; used by hazard logic to stall
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int         c_DEPTH = 1 << ADDR_W;
  localparam logic [3:0] c_LAT   = 4'(LATENCY);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WAIT  = 2'd1;
  localparam logic [1:0] c_RESP  = 2'd2;

  // --------------------------------------------------------------------------
  // State and request capture
  // --------------------------------------------------------------------------
  logic [1:0]        state_q,     state_d;
  logic [3:0]        cnt_q,       cnt_d;
  logic              wr_q,        wr_d;
  logic [15:0]       addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;

  logic [DATA_W-1:0] mem [0:c_DEPTH-1];

  logic              w_addr_err;
  logic              w_access;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_rdata;

  // Upper address bits set means out of range. When the full 16 bits are
  // decoded there are no upper bits and no address can be out of range.
  generate
    if (ADDR_W < 16) begin : g_err_decode
      assign w_addr_err = |addr_q[15:ADDR_W];
    end else begin : g_err_none
      assign w_addr_err = 1'b0;
    end
  endgenerate

  // The access edge is the last edge spent in WAIT.
  assign w_access    = (state_q == c_WAIT) && (cnt_q == 4'd0);
  assign w_mem_we    = w_access && wr_q && !w_addr_err;
  assign w_mem_rdata = mem[addr_q[ADDR_W-1:0]];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      c_IDLE: begin
        // req_ready is 1 throughout IDLE, so req_valid alone completes the handshake.
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = c_LAT;
          state_d = c_WAIT;
        end
      end

      c_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d     = c_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = w_addr_err;
          // Stores and out-of-range loads return zero.
          rsp_rdata_d = (!wr_q && !w_addr_err) ? w_mem_rdata : '0;
        end
      end

      c_RESP: begin
        // rsp_valid is always 1 in RESP, so rsp_ready alone completes the handshake.
        if (rsp_ready) begin
          state_d     = c_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end

      default: begin
        state_d     = c_IDLE;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= c_IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= 16'd0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage array. It is not reset. Reset clears state_q asynchronously, so
  // the write enable drops at once. A store that has not yet reached its
  // access edge is therefore lost when reset is asserted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem[addr_q[ADDR_W-1:0]] <= wdata_q;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_ready = (state_q == c_IDLE);
  assign busy      = (state_q != c_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
